// File: rtl/macc_array.sv
// macc_array: NUM_LANES signed fixed-point MUL/MAC/MADD lanes sharing one op code.
// Four-stage pipeline with whole-pipe backpressure, round-half-up and saturation.
module macc_array #(
    parameter int NUM_LANES = 4,
    parameter int OP_WIDTH  = 16,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [2:0]                     op_code,
    input  logic [NUM_LANES*OP_WIDTH-1:0]  op_0,
    input  logic [NUM_LANES*OP_WIDTH-1:0]  op_1,
    input  logic [NUM_LANES*OP_WIDTH-1:0]  op_add,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]           out_sat
);
    localparam int N  = NUM_LANES;
    localparam int PW = 2 * OP_WIDTH;
    localparam int XW = ACC_WIDTH - OUT_WIDTH + 2;

    typedef logic signed [OP_WIDTH-1:0]  op_t;
    typedef logic signed [PW-1:0]        prod_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [ACC_WIDTH:0]   wide_t;

    localparam wide_t ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam wide_t ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam wide_t OUT_MAX = {{XW{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam wide_t OUT_MIN = {{XW{1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam wide_t HALF    = wide_t'(1) <<< (FRAC_BITS - 1);
    localparam logic [1:0] M_MUL  = 2'b00;
    localparam logic [1:0] M_MADD = 2'b10;

    logic                   stall, adv, is_mul, is_madd, is_mac;
    logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [1:0]             s1_mode_q, s1_mode_d;
    op_t                    s1_a_q [N], s1_a_d [N];
    op_t                    s1_b_q [N], s1_b_d [N];
    op_t                    s1_add_q [N], s1_add_d [N];
    logic                   s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [1:0]             s2_mode_q, s2_mode_d;
    prod_t                  s2_prod_q [N], s2_prod_d [N];
    op_t                    s2_add_q [N], s2_add_d [N];
    logic                   s3_valid_q, s3_valid_d, first_q, first_d;
    acc_t                   s3_res_q [N], s3_res_d [N];
    acc_t                   acc_q [N], acc_d [N];
    logic [N-1:0]           s3_ovf_q, s3_ovf_d, acc_ovf_q, acc_ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [N*OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [N-1:0]           out_sat_q, out_sat_d;
    wide_t                  prod_w, add_w, base_w, sum_w, rnd_w;
    acc_t                   res;
    logic                   clamp, ovf_run, oclamp;
    logic [OUT_WIDTH-1:0]   lane_w;

    assign stall    = out_valid_q && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;
    assign is_mul   = (s2_mode_q == M_MUL);
    assign is_madd  = (s2_mode_q == M_MADD);
    assign is_mac   = !is_mul && !is_madd;

    always_comb begin : s1_comb
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_add_d   = s1_add_q;
        if (clear) begin
            s1_valid_d = 1'b0;
        end else if (adv) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            s1_mode_d  = op_code[2:1];
            for (int l = 0; l < N; l++) begin
                s1_a_d[l]   = op_0[l*OP_WIDTH +: OP_WIDTH];
                s1_b_d[l]   = op_code[0] ? op_0[l*OP_WIDTH +: OP_WIDTH]
                                         : op_1[l*OP_WIDTH +: OP_WIDTH];
                s1_add_d[l] = op_add[l*OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    always_comb begin : s2_comb
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_mode_d  = s2_mode_q;
        s2_prod_d  = s2_prod_q;
        s2_add_d   = s2_add_q;
        if (clear) begin
            s2_valid_d = 1'b0;
        end else if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_mode_d  = s1_mode_q;
            for (int l = 0; l < N; l++) begin
                s2_prod_d[l] = prod_t'(s1_a_q[l]) * prod_t'(s1_b_q[l]);
                s2_add_d[l]  = s1_add_q[l];
            end
        end
    end

    // MUL/MADD beats pass through S3 without touching the MAC accumulator
    always_comb begin : s3_comb
        s3_valid_d = s3_valid_q;
        first_d    = first_q;
        s3_res_d   = s3_res_q;
        s3_ovf_d   = s3_ovf_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;
        prod_w     = '0;
        add_w      = '0;
        base_w     = '0;
        sum_w      = '0;
        res        = '0;
        clamp      = 1'b0;
        ovf_run    = 1'b0;
        if (clear) begin
            s3_valid_d = 1'b0;
            first_d    = 1'b1;
        end else if (adv) begin
            s3_valid_d = s2_valid_q && (!is_mac || s2_last_q);
            for (int l = 0; l < N; l++) begin
                prod_w = wide_t'(s2_prod_q[l]);
                add_w  = wide_t'(s2_add_q[l]) <<< FRAC_BITS;
                base_w = '0;
                if (!first_q) base_w = wide_t'(acc_q[l]);
                unique case (1'b1)
                    is_mul:  sum_w = prod_w;
                    is_madd: sum_w = prod_w + add_w;
                    default: sum_w = base_w + prod_w;
                endcase
                clamp = 1'b0;
                res   = sum_w[ACC_WIDTH-1:0];
                if (sum_w > ACC_MAX) begin
                    clamp = 1'b1;
                    res   = ACC_MAX[ACC_WIDTH-1:0];
                end else if (sum_w < ACC_MIN) begin
                    clamp = 1'b1;
                    res   = ACC_MIN[ACC_WIDTH-1:0];
                end
                ovf_run = clamp | (acc_ovf_q[l] & !first_q);
                if (s2_valid_q) begin
                    s3_res_d[l] = res;
                    s3_ovf_d[l] = is_mac ? ovf_run : clamp;
                    if (is_mac) begin
                        acc_d[l]     = res;
                        acc_ovf_d[l] = ovf_run;
                    end
                end
            end
            if (s2_valid_q && is_mac) first_d = s2_last_q;
        end
    end

    always_comb begin : s4_comb
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        rnd_w       = '0;
        lane_w      = '0;
        oclamp      = 1'b0;
        if (adv) begin
            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                for (int l = 0; l < N; l++) begin
                    rnd_w  = (wide_t'(s3_res_q[l]) + HALF) >>> FRAC_BITS;
                    oclamp = 1'b0;
                    lane_w = rnd_w[OUT_WIDTH-1:0];
                    if (rnd_w > OUT_MAX) begin
                        oclamp = 1'b1;
                        lane_w = OUT_MAX[OUT_WIDTH-1:0];
                    end else if (rnd_w < OUT_MIN) begin
                        oclamp = 1'b1;
                        lane_w = OUT_MIN[OUT_WIDTH-1:0];
                    end
                    out_data_d[l*OUT_WIDTH +: OUT_WIDTH] = lane_w;
                    out_sat_d[l] = oclamp | s3_ovf_q[l];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_mode_q   <= '0;
            s3_valid_q  <= 1'b0;
            first_q     <= 1'b1;
            s3_ovf_q    <= '0;
            acc_ovf_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int l = 0; l < N; l++) begin
                s1_a_q[l]    <= '0;
                s1_b_q[l]    <= '0;
                s1_add_q[l]  <= '0;
                s2_prod_q[l] <= '0;
                s2_add_q[l]  <= '0;
                s3_res_q[l]  <= '0;
                acc_q[l]     <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_add_q    <= s1_add_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_mode_q   <= s2_mode_d;
            s2_prod_q   <= s2_prod_d;
            s2_add_q    <= s2_add_d;
            s3_valid_q  <= s3_valid_d;
            first_q     <= first_d;
            s3_res_q    <= s3_res_d;
            s3_ovf_q    <= s3_ovf_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
